// File: rtl/mpt_pkg.sv
`default_nettype none
//============================================================================
// mpt_pkg: shared MPT types, widths and responder state encoding.  Rev 1.0
//============================================================================
package mpt_pkg;

  localparam int XLEN        = 64;
  localparam int MPTSIZE     = XLEN / 8;           // bytes per table entry
  localparam int ENTRY_SHIFT = $clog2(MPTSIZE);
  localparam int CNT_W       = 4;                  // delay/latency counters cover 0..15

  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [8:0]  perms;
    logic        v;
  } mpt_entry_t;

  typedef enum logic [2:0] {
    RESP_IDLE    = 3'd0,
    RESP_STALL   = 3'd1,
    RESP_GRANT   = 3'd2,
    RESP_LATENCY = 3'd3,
    RESP_RESPOND = 3'd4
  } mpt_resp_state_e;

endpackage
`default_nettype wire

// File: rtl/mpt_table_ram.sv
`default_nettype none
//============================================================================
// mpt_table_ram: MPT word storage, one sync write port, one async read port.
// Rev 1.0
//============================================================================
module mpt_table_ram
  import mpt_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]  wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [XLEN-1:0]  rdata
);

  // No reset: contents are undefined until programmed.
  mpt_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= mpt_entry_t'(wdata);
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/mpt_mem_responder.sv
`default_nettype none
//============================================================================
// mpt_mem_responder: single-outstanding MPT table read responder with
// programmable grant delay and response latency.  Rev 1.0
//============================================================================
module mpt_mem_responder
  import mpt_pkg::*;
#(
  parameter int              DEPTH      = 256,
  parameter logic [XLEN-1:0] BASE_ADDR  = 64'h8000_0000,
  parameter int              GNT_DELAY  = 0,
  parameter int              RVALID_LAT = 1,
  localparam int             IDX_W      = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic [XLEN-1:0]  addr_i,
  output logic             gnt_o,
  output logic             rvalid_o,
  output logic [XLEN-1:0]  rdata_o,
  output logic             err_o,
  input  logic             flush_i,
  input  logic             cfg_we_i,
  input  logic [IDX_W-1:0] cfg_idx_i,
  input  logic [XLEN-1:0]  cfg_wdata_i
);

  mpt_resp_state_e  state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [XLEN-1:0]  off;
  logic [IDX_W-1:0] rd_idx;
  logic [XLEN-1:0]  ram_rdata;
  logic [XLEN-1:0]  rd_data;
  logic             misaligned;
  logic             below_base;
  logic             out_of_range;
  logic             lookup_err;
  logic [XLEN-1:0]  lookup_data;
  logic [XLEN-1:0]  data_q;
  logic             err_q;

  mpt_table_ram #(
    .DEPTH (DEPTH)
  ) u_table (
    .clk   (clk_i),
    .we    (cfg_we_i),
    .waddr (cfg_idx_i),
    .wdata (cfg_wdata_i),
    .raddr (rd_idx),
    .rdata (ram_rdata)
  );

  // BASE_ADDR is entry-aligned, so the low offset bits equal the low address bits.
  assign off          = addr_i - BASE_ADDR;
  assign misaligned   = |off[ENTRY_SHIFT-1:0];
  assign below_base   = addr_i < BASE_ADDR;
  assign out_of_range = |off[XLEN-1:ENTRY_SHIFT+IDX_W];
  assign rd_idx       = off[ENTRY_SHIFT +: IDX_W];
  assign lookup_err   = misaligned | below_base | out_of_range;

  // Write-first: a same-cycle programming write to the word being read wins.
  assign rd_data     = (cfg_we_i && (cfg_idx_i == rd_idx)) ? cfg_wdata_i : ram_rdata;
  assign lookup_data = lookup_err ? '0 : rd_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= RESP_IDLE;
      cnt    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == RESP_GRANT) begin
        data_q <= lookup_data;
        err_q  <= lookup_err;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RESP_IDLE: begin
        if (req_i) begin
          if (GNT_DELAY == 0) begin
            state_nxt = RESP_GRANT;
          end else begin
            cnt_nxt   = CNT_W'(GNT_DELAY);
            state_nxt = RESP_STALL;
          end
        end
      end
      RESP_STALL: begin
        if (flush_i || !req_i) begin
          cnt_nxt   = '0;
          state_nxt = RESP_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_nxt = RESP_GRANT;
          end
        end
      end
      RESP_GRANT: begin
        if (flush_i) begin
          state_nxt = RESP_IDLE;
        end else if (RVALID_LAT == 1) begin
          state_nxt = RESP_RESPOND;
        end else begin
          cnt_nxt   = CNT_W'(RVALID_LAT - 1);
          state_nxt = RESP_LATENCY;
        end
      end
      RESP_LATENCY: begin
        if (flush_i) begin
          cnt_nxt   = '0;
          state_nxt = RESP_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_nxt = RESP_RESPOND;
          end
        end
      end
      RESP_RESPOND: begin
        state_nxt = RESP_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = RESP_IDLE;
      end
    endcase
  end

  assign gnt_o    = (state == RESP_GRANT);
  assign rvalid_o = (state == RESP_RESPOND);
  assign rdata_o  = rvalid_o ? data_q : '0;
  assign err_o    = rvalid_o & err_q;

endmodule
`default_nettype wire

// File: tb/tb_mpt_mem_responder.sv
`default_nettype none
//============================================================================
// tb_mpt_mem_responder: randomized self-checking bench, three timing configs.
// Rev 1.0
//============================================================================
module tb_mpt_mem_responder;

  localparam int          N     = 3;
  localparam int          DEPTH = 16;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic             clk = 1'b0;
  logic [N-1:0]     rst_n;
  logic [N-1:0]     req;
  logic [N-1:0]     flush;
  logic [N-1:0]     cfg_we;
  logic [N-1:0]     gnt;
  logic [N-1:0]     rvalid;
  logic [N-1:0]     err;
  logic [63:0]      addr      [N];
  logic [63:0]      rdata     [N];
  logic [3:0]       cfg_idx   [N];
  logic [63:0]      cfg_wdata [N];

  logic [63:0] mem_m [N][DEPTH];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mpt_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .GNT_DELAY(0), .RVALID_LAT(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .addr_i(addr[0]), .gnt_o(gnt[0]),
    .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]), .flush_i(flush[0]),
    .cfg_we_i(cfg_we[0]), .cfg_idx_i(cfg_idx[0]), .cfg_wdata_i(cfg_wdata[0]));

  mpt_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .GNT_DELAY(3), .RVALID_LAT(4)) dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .addr_i(addr[1]), .gnt_o(gnt[1]),
    .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]), .flush_i(flush[1]),
    .cfg_we_i(cfg_we[1]), .cfg_idx_i(cfg_idx[1]), .cfg_wdata_i(cfg_wdata[1]));

  mpt_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .GNT_DELAY(2), .RVALID_LAT(3)) dut2 (
    .clk_i(clk), .rst_ni(rst_n[2]), .req_i(req[2]), .addr_i(addr[2]), .gnt_o(gnt[2]),
    .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]), .flush_i(flush[2]),
    .cfg_we_i(cfg_we[2]), .cfg_idx_i(cfg_idx[2]), .cfg_wdata_i(cfg_wdata[2]));

  function automatic int gdel(input int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : 2;
  endfunction

  function automatic int glat(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 3;
  endfunction

  function automatic void model_read(input int k, input logic [63:0] a,
                                     output logic e, output logic [63:0] d);
    e = 1'b1;
    d = 64'h0;
    if ((a % 64'd8 == 64'd0) && (a >= BASE) && ((a - BASE) / 64'd8 < 64'(DEPTH))) begin
      e = 1'b0;
      d = mem_m[k][int'((a - BASE) / 64'd8)];
    end
  endfunction

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    case ($urandom_range(0, 5))
      0, 1, 2: a = BASE + 64'(8 * $urandom_range(0, DEPTH - 1));
      3:       a = BASE + 64'(8 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(1, 7));
      4:       a = BASE - 64'(8 * $urandom_range(1, 64));
      default: a = BASE + 64'(DEPTH * 8) + 64'(8 * $urandom_range(0, 1000));
    endcase
    return a;
  endfunction

  task automatic cfg_write(input int k, input int idx, input logic [63:0] d);
    @(negedge clk);
    cfg_we[k]    = 1'b1;
    cfg_idx[k]   = 4'(idx);
    cfg_wdata[k] = d;
    @(negedge clk);
    cfg_we[k] = 1'b0;
    mem_m[k][idx] = d;
  endtask

  // One read transaction; cycle 0 is the cycle req_i is first presented.
  // flush_at < 0 disables flush; do_wr issues a programming write in the grant cycle.
  task automatic run_txn(input int k, input logic [63:0] a, input int flush_at,
                         input bit do_wr, input int wr_idx, input logic [63:0] wr_data,
                         input string tag);
    int          g_exp, rv_exp;
    bit          nogrant, killed;
    logic        exp_g, exp_rv, exp_err;
    logic [63:0] exp_data;
    g_exp   = 1 + gdel(k);
    rv_exp  = g_exp + glat(k);
    nogrant = (flush_at >= 1) && (flush_at < g_exp);
    killed  = (flush_at >= 1) && (flush_at < rv_exp);
    model_read(k, a, exp_err, exp_data);
    if (do_wr && !nogrant && !exp_err && (wr_idx == int'((a - BASE) / 64'd8))) exp_data = wr_data;
    @(negedge clk);
    req[k]   = 1'b1;
    addr[k]  = a;
    flush[k] = (flush_at == 0);
    for (int cyc = 1; cyc <= rv_exp + 2; cyc++) begin
      @(negedge clk);
      exp_g  = (cyc == g_exp) && !nogrant;
      exp_rv = (cyc == rv_exp) && !killed;
      checks++;
      if (gnt[k] !== exp_g) begin
        failures++;
        $display("FAIL %s gnt cyc=%0d got=%b exp=%b", tag, cyc, gnt[k], exp_g);
      end
      checks++;
      if (rvalid[k] !== exp_rv) begin
        failures++;
        $display("FAIL %s rvalid cyc=%0d got=%b exp=%b", tag, cyc, rvalid[k], exp_rv);
      end
      checks++;
      if (err[k] !== (exp_rv ? exp_err : 1'b0)) begin
        failures++;
        $display("FAIL %s err cyc=%0d got=%b exp=%b", tag, cyc, err[k], exp_rv ? exp_err : 1'b0);
      end
      checks++;
      if (rdata[k] !== (exp_rv ? exp_data : 64'h0)) begin
        failures++;
        $display("FAIL %s rdata cyc=%0d got=%h exp=%h", tag, cyc, rdata[k], exp_rv ? exp_data : 64'h0);
      end
      flush[k] = (cyc == flush_at);
      if ((cyc == g_exp) || ((cyc == flush_at) && nogrant)) req[k] = 1'b0;
      if (do_wr && !nogrant && (cyc == g_exp)) begin
        cfg_we[k]    = 1'b1;
        cfg_idx[k]   = 4'(wr_idx);
        cfg_wdata[k] = wr_data;
      end else begin
        cfg_we[k] = 1'b0;
      end
    end
    req[k]    = 1'b0;
    flush[k]  = 1'b0;
    cfg_we[k] = 1'b0;
    if (do_wr && !nogrant) mem_m[k][wr_idx] = wr_data;
  endtask

  task automatic check_quiet(input int k, input string tag);
    checks++;
    if ({gnt[k], rvalid[k], err[k]} !== 3'b000 || rdata[k] !== 64'h0) begin
      failures++;
      $display("FAIL %s got gnt=%b rvalid=%b err=%b rdata=%h exp all zero",
               tag, gnt[k], rvalid[k], err[k], rdata[k]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) check_quiet(k, "reset_outputs");
    rst_n = '1;
    @(negedge clk);
    for (int k = 0; k < N; k++) check_quiet(k, "post_reset_idle");
  endtask

  task automatic init_tables();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < DEPTH; i++) cfg_write(k, i, {$urandom, $urandom});
  endtask

  task automatic test_basic();
    cfg_write(0, 3, 64'h0000_0000_0000_1003);
    run_txn(0, 64'h8000_0018, -1, 1'b0, 0, 64'h0, "basic_idx3");
  endtask

  task automatic test_latency();
    run_txn(1, BASE, -1, 1'b0, 0, 64'h0, "delay3_lat4_idx0");
    run_txn(2, BASE + 64'd8 * 64'(DEPTH - 1), -1, 1'b0, 0, 64'h0, "delay2_lat3_last");
  endtask

  task automatic test_errors();
    run_txn(0, 64'h8000_0004, -1, 1'b0, 0, 64'h0, "err_misaligned");
    run_txn(0, 64'h7FFF_FFF8, -1, 1'b0, 0, 64'h0, "err_below_base");
    run_txn(0, BASE + 64'(DEPTH * 8), -1, 1'b0, 0, 64'h0, "err_past_end");
    run_txn(1, 64'hFFFF_FFFF_FFFF_FFF8, -1, 1'b0, 0, 64'h0, "err_top_of_space");
  endtask

  task automatic test_flush();
    run_txn(1, BASE + 64'd16, 5, 1'b0, 0, 64'h0, "flush_latency");
    run_txn(1, BASE + 64'd8,  -1, 1'b0, 0, 64'h0, "after_flush_idx1");
    run_txn(1, BASE + 64'd8,  2, 1'b0, 0, 64'h0, "flush_stall");
    run_txn(1, BASE + 64'd8,  4, 1'b0, 0, 64'h0, "flush_grant");
    run_txn(1, BASE + 64'd8,  8, 1'b0, 0, 64'h0, "flush_respond");
    run_txn(0, BASE + 64'd40, 0, 1'b0, 0, 64'h0, "flush_idle");
  endtask

  task automatic test_write_first();
    run_txn(0, BASE + 64'd40, -1, 1'b1, 5, 64'hAB, "write_first_idx5");
    run_txn(0, BASE + 64'd40, -1, 1'b0, 0, 64'h0,  "readback_idx5");
    run_txn(1, BASE + 64'd48, -1, 1'b1, 7, 64'h1234, "write_other_idx");
  endtask

  task automatic test_req_drop();
    @(negedge clk);
    req[2]  = 1'b1;
    addr[2] = BASE + 64'd24;
    @(negedge clk);
    req[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_quiet(2, "req_drop_no_grant");
    end
    run_txn(2, BASE + 64'd24, -1, 1'b0, 0, 64'h0, "after_req_drop");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req[2]  = 1'b1;
    addr[2] = BASE + 64'd16;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (cyc == 3) begin
        checks++;
        if (gnt[2] !== 1'b1) begin
          failures++;
          $display("FAIL reset_mid_grant got=%b exp=1", gnt[2]);
        end
        req[2] = 1'b0;
      end
    end
    rst_n[2] = 1'b0;
    #1;
    check_quiet(2, "reset_mid_async");
    @(negedge clk);
    rst_n[2] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_quiet(2, "reset_mid_discard");
    end
    run_txn(2, BASE + 64'd16, -1, 1'b0, 0, 64'h0, "after_reset_mid");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int          k, f, widx;
      bit          w;
      logic [63:0] a;
      k    = $urandom_range(0, N - 1);
      a    = rand_addr();
      f    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, gdel(k) + glat(k) + 1)) : -1;
      w    = ($urandom_range(0, 2) == 0);
      widx = $urandom_range(0, DEPTH - 1);
      if (w && $urandom_range(0, 1) == 1 && a >= BASE && (a - BASE) / 64'd8 < 64'(DEPTH))
        widx = int'((a - BASE) / 64'd8);
      run_txn(k, a, f, w, widx, {$urandom, $urandom}, "random");
    end
  endtask

  initial begin
    rst_n  = '0;
    req    = '0;
    flush  = '0;
    cfg_we = '0;
    for (int k = 0; k < N; k++) begin
      addr[k]      = 64'h0;
      cfg_idx[k]   = 4'h0;
      cfg_wdata[k] = 64'h0;
    end
    test_reset();
    init_tables();
    test_basic();
    test_latency();
    test_errors();
    test_flush();
    test_write_first();
    test_req_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
